// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: FSM states, owners,
// MEM length codes and the length-to-byte-count helper.
package mem_ctrl_pkg;
  localparam int unsigned ADDR_W_DEF = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  typedef enum logic { ST_IDLE = 1'b0, ST_BUSY = 1'b1 } state_e;
  typedef enum logic { OWN_IF = 1'b0, OWN_MEM = 1'b1 } owner_e;

  // Byte count for a MEM length code; the illegal code 2 falls back to a word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   len_bytes = 3'd1;
      LEN_H:   len_bytes = 3'd2;
      LEN_W:   len_bytes = 3'd4;
      default: len_bytes = 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IF and MEM onto one byte-wide RAM port, serialising each access
// into per-byte cycles and reassembling reads little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              if_stall,
  output logic              mem_stall,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);
  state_e            state;
  owner_e            owner;
  logic              we;
  logic [2:0]        nbytes;
  logic [ADDR_W-1:0] base;
  logic [2:0]        cnt;
  logic [31:0]       wdata;
  logic [31:0]       rbuf;
  logic [31:0]       rd_word;
  logic              ram_wr_q;
  logic [2:0]        cnt_nxt;
  logic [1:0]        lane_prev;
  logic [1:0]        lane_nxt;

  assign cnt_nxt   = cnt + 3'd1;
  assign lane_prev = 2'(cnt - 3'd1);
  assign lane_nxt  = 2'(cnt_nxt);

  assign if_stall  = if_req & ~if_done;
  assign mem_stall = mem_req & ~mem_done;
  assign ram_wr    = ram_wr_q & rdy;

  // Final read word: buffered lanes plus the byte arriving this cycle, zero-filled.
  always_comb begin
    rd_word = rbuf;
    rd_word[{lane_prev, 3'b000} +: 8] = ram_din;
    case (nbytes)
      3'd1:    rd_word = {24'h0, rd_word[7:0]};
      3'd2:    rd_word = {16'h0, rd_word[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      we        <= FALSE;
      nbytes    <= 3'd4;
      base      <= '0;
      cnt       <= '0;
      wdata     <= '0;
      rbuf      <= '0;
      if_done   <= FALSE;
      mem_done  <= FALSE;
      if_inst   <= '0;
      mem_rdata <= '0;
      ram_a     <= IDLE_ADDR;
      ram_dout  <= '0;
      ram_wr_q  <= FALSE;
    end else if (rdy) begin
      if_done  <= FALSE;
      mem_done <= FALSE;
      case (state)
        ST_IDLE: begin
          // Skip the done cycle so the served client can drop its request.
          if (!if_done && !mem_done) begin
            if (mem_req) begin
              state    <= ST_BUSY;
              owner    <= OWN_MEM;
              we       <= mem_we;
              nbytes   <= len_bytes(mem_len);
              base     <= mem_addr;
              wdata    <= mem_wdata;
              cnt      <= '0;
              ram_a    <= mem_addr;
              ram_wr_q <= mem_we;
              ram_dout <= mem_we ? mem_wdata[7:0] : 8'h00;
            end else if (if_req) begin
              state    <= ST_BUSY;
              owner    <= OWN_IF;
              we       <= FALSE;
              nbytes   <= 3'd4;
              base     <= if_addr;
              cnt      <= '0;
              ram_a    <= if_addr;
              ram_wr_q <= FALSE;
              ram_dout <= 8'h00;
            end
          end
        end
        ST_BUSY: begin
          if (owner == OWN_IF && !if_req) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ram_a    <= IDLE_ADDR;
            ram_wr_q <= FALSE;
          end else if (we) begin
            if (cnt == nbytes - 3'd1) begin
              state    <= ST_IDLE;
              cnt      <= '0;
              mem_done <= TRUE;
              ram_a    <= IDLE_ADDR;
              ram_wr_q <= FALSE;
              ram_dout <= 8'h00;
            end else begin
              cnt      <= cnt_nxt;
              ram_a    <= base + ADDR_W'(cnt_nxt);
              ram_dout <= wdata[{lane_nxt, 3'b000} +: 8];
            end
          end else begin
            if (cnt != 3'd0) rbuf[{lane_prev, 3'b000} +: 8] <= ram_din;
            if (cnt == nbytes) begin
              state <= ST_IDLE;
              cnt   <= '0;
              if (owner == OWN_IF) begin
                if_done <= TRUE;
                if_inst <= rd_word;
              end else begin
                mem_done  <= TRUE;
                mem_rdata <= rd_word;
              end
            end else begin
              cnt   <= cnt_nxt;
              ram_a <= (cnt_nxt == nbytes) ? IDLE_ADDR : base + ADDR_W'(cnt_nxt);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Length code 2 is a protocol violation from the MEM stage.
  mem_len_legal: assert property (@(posedge clk) disable iff (!rst_n)
                                  (rdy && mem_req) |-> (mem_len != 2'd2));
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: transaction-level schedule model with rdy freeze,
// RAM model, and one per-cycle compare process.
module tb_mem_ctrl;
  localparam logic [31:0] IDLE_A = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n, rdy;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic        if_done, mem_done, if_stall, mem_stall, ram_wr;
  logic [31:0] if_inst, mem_rdata, ram_a;
  logic [7:0]  ram_din, ram_dout;

  mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .if_stall(if_stall), .mem_stall(mem_stall),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic        if_done;
    logic        mem_done;
    logic [31:0] if_inst;
    logic [31:0] mem_rdata;
  } cyc_t;

  cyc_t        plan[$];
  cyc_t        cur;
  bit          chk_en = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          done_real;
  logic [31:0] m_if_inst, m_mem_rdata;
  logic [7:0]  ref_mem[logic [31:0]];
  logic [7:0]  ram[logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return init_byte(a);
  endfunction

  // RAM device: registered read, holds output while rdy is low.
  always @(posedge clk) begin
    if (rdy) begin
      if (ram_wr) ram[ram_a] = ram_dout;
      ram_din <= ram_rd(ram_a);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp_v);
    end
  endtask

  function automatic cyc_t idle_rec();
    cyc_t r;
    r = '0;
    r.ram_a     = IDLE_A;
    r.if_inst   = m_if_inst;
    r.mem_rdata = m_mem_rdata;
    return r;
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) plan.push_back(idle_rec());
  endfunction

  // Nominal (no-stall) schedule of one access whose request rises in cycle 0.
  function automatic int add_seg(input bit is_if, input bit we, input logic [31:0] addr,
                                 input logic [1:0] len, input logic [31:0] wdata,
                                 input int abort_at, input bit if_bg, input logic [31:0] bg_addr);
    int n, last, start;
    logic [31:0] rd;
    n = is_if ? 4 : (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    if (is_if) we = 1'b0;
    last  = we ? n + 1 : n + 2;
    start = plan.size();
    rd    = '0;
    for (int i = 0; i < n; i++) rd[8*i +: 8] = ref_rd(addr + 32'(i));
    for (int k = 0; k <= last; k++) begin
      cyc_t r;
      if (abort_at >= 0 && k > abort_at) break;
      r = idle_rec();
      if (is_if) begin
        r.if_req  = (abort_at < 0) || (k < abort_at);
        r.if_addr = addr;
      end else begin
        r.mem_req = 1'b1; r.mem_we = we; r.mem_len = len;
        r.mem_addr = addr; r.mem_wdata = wdata;
        if (if_bg) begin r.if_req = 1'b1; r.if_addr = bg_addr; end
      end
      if (k >= 1 && k <= n) begin
        r.ram_a = addr + 32'(k - 1);
        if (we) begin r.ram_wr = 1'b1; r.ram_dout = wdata[8*(k-1) +: 8]; end
      end
      if (k == last) begin
        if (is_if) begin
          m_if_inst = rd; r.if_done = 1'b1; r.if_inst = rd;
        end else begin
          r.mem_done = 1'b1;
          if (!we) begin m_mem_rdata = rd; r.mem_rdata = rd; end
        end
      end
      plan.push_back(r);
    end
    if (we) for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
    return start;
  endfunction

  task automatic drive(input cyc_t r);
    if_req = r.if_req; if_addr = r.if_addr;
    mem_req = r.mem_req; mem_we = r.mem_we; mem_len = r.mem_len;
    mem_addr = r.mem_addr; mem_wdata = r.mem_wdata;
  endtask

  // Play the schedule: a low-rdy cycle repeats the same nominal step.
  task automatic play(input int mode);
    int p, rc, lows;
    p = 0; rc = 0; lows = 0; done_real = -1;
    while (p < plan.size()) begin
      cur = plan[p];
      drive(cur);
      case (mode)
        1:       rdy = (lows < 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
        2:       rdy = !(rc >= 2 && rc <= 4);
        default: rdy = 1'b1;
      endcase
      lows = rdy ? 0 : lows + 1;
      if (cur.mem_done && done_real < 0) done_real = rc;
      chk_en = 1'b1;
      @(posedge clk); #1;
      if (rdy) p++;
      rc++;
      if (rc > 20000) begin
        n_tests++; n_fail++;
        $display("FAIL play_budget: got %0d cycles, expected under 20000", rc);
        break;
      end
    end
    chk_en = 1'b0;
    rdy = 1'b1;
    plan.delete();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ram_a", ram_a, cur.ram_a);
      check("ram_wr", 32'(ram_wr), 32'(cur.ram_wr & rdy));
      if (cur.ram_wr) check("ram_dout", 32'(ram_dout), 32'(cur.ram_dout));
      check("if_done", 32'(if_done), 32'(cur.if_done));
      check("mem_done", 32'(mem_done), 32'(cur.mem_done));
      check("if_inst", if_inst, cur.if_inst);
      check("mem_rdata", mem_rdata, cur.mem_rdata);
      check("if_stall", 32'(if_stall), 32'(cur.if_req & ~cur.if_done));
      check("mem_stall", 32'(mem_stall), 32'(cur.mem_req & ~cur.mem_done));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, s2, s3, s4, s5, s6, s7;
    rst_n = 1'b0; rdy = 1'b1;
    if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_len = 0;
    mem_addr = 0; mem_wdata = 0;
    m_if_inst = '0; m_mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_if_done", 32'(if_done), 0);
    check("rst_mem_done", 32'(mem_done), 0);
    check("rst_ram_wr", 32'(ram_wr), 0);
    check("rst_ram_dout", 32'(ram_dout), 0);
    check("rst_ram_a", ram_a, IDLE_A);
    check("rst_if_inst", if_inst, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed scenarios with model pins.
    ref_mem[32'h1000] = 8'h13; ref_mem[32'h1001] = 8'h05;
    ref_mem[32'h1002] = 8'h10; ref_mem[32'h1003] = 8'h00;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05;
    ram[32'h1002] = 8'h10; ram[32'h1003] = 8'h00;
    s0 = add_seg(1'b1, 1'b0, 32'h1000, 2'd3, 0, -1, 1'b0, 0);
    add_idle(2);
    s1 = add_seg(1'b0, 1'b1, 32'h20, 2'd3, 32'hDEADBEEF, -1, 1'b0, 0);
    add_idle(1);
    s2 = add_seg(1'b0, 1'b0, 32'h20, 2'd3, 0, -1, 1'b0, 0);
    s3 = add_seg(1'b0, 1'b0, 32'h21, 2'd0, 0, -1, 1'b0, 0);
    s4 = add_seg(1'b0, 1'b0, 32'h22, 2'd1, 0, -1, 1'b1, 32'h1000);
    s5 = add_seg(1'b1, 1'b0, 32'h1000, 2'd3, 0, -1, 1'b0, 0);
    s6 = add_seg(1'b1, 1'b0, 32'h1004, 2'd3, 0, 2, 1'b0, 0);
    s7 = add_seg(1'b1, 1'b0, 32'h1000, 2'd3, 0, -1, 1'b0, 0);
    add_idle(2);
    check("pin_if_a1", plan[s0+1].ram_a, 32'h1000);
    check("pin_if_a4", plan[s0+4].ram_a, 32'h1003);
    check("pin_if_done6", 32'(plan[s0+6].if_done), 1);
    check("pin_if_inst", plan[s0+6].if_inst, 32'h00100513);
    check("pin_st_b0", 32'(plan[s1+1].ram_dout), 32'hEF);
    check("pin_st_b3", 32'(plan[s1+4].ram_dout), 32'hDE);
    check("pin_st_done5", 32'(plan[s1+5].mem_done), 1);
    check("pin_ld_word", plan[s2+6].mem_rdata, 32'hDEADBEEF);
    check("pin_ld_byte", plan[s3+3].mem_rdata, 32'h000000BE);
    check("pin_ld_half", plan[s4+4].mem_rdata, 32'h0000DEAD);
    check("pin_pair_gap", 32'(s5 - s4), 5);
    check("pin_abort_gap", 32'(s7 - s6), 3);
    play(0);

    // rdy low for three cycles in the middle of a word load.
    s0 = add_seg(1'b0, 1'b0, 32'h20, 2'd3, 0, -1, 1'b0, 0);
    add_idle(1);
    play(2);
    check("stall_done_cycle", 32'(done_real), 9);

    // Async reset in the middle of a word store: bytes 0 and 1 already issued.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h300; mem_len = 2'd3;
    mem_wdata = 32'hA1B2C3D4; rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_store_wr", 32'(ram_wr), 1);
    check("mid_store_a", ram_a, 32'h302);
    #2; rst_n = 1'b0; #1;
    check("arst_ram_wr", 32'(ram_wr), 0);
    check("arst_ram_a", ram_a, IDLE_A);
    check("arst_ram_dout", 32'(ram_dout), 0);
    check("arst_if_inst", if_inst, 0);
    check("arst_mem_rdata", mem_rdata, 0);
    check("arst_mem_done", 32'(mem_done), 0);
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    ref_mem[32'h300] = 8'hD4; ref_mem[32'h301] = 8'hC3;
    m_if_inst = '0; m_mem_rdata = '0;
    s0 = add_seg(1'b0, 1'b0, 32'h300, 2'd3, 0, -1, 1'b0, 0);
    s1 = add_seg(1'b1, 1'b0, 32'h1000, 2'd3, 0, -1, 1'b0, 0);
    add_idle(1);
    check("pin_partial", plan[s0+6].mem_rdata,
          {init_byte(32'h303), init_byte(32'h302), 16'hC3D4});
    play(0);

    // Randomized mix with random rdy.
    for (int t = 0; t < 60; t++) begin
      int kind;
      logic [31:0] a, a2, wd;
      logic [1:0] ln;
      kind = $urandom_range(0, 5);
      a  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                       : 32'h400 + 32'($urandom_range(0, 63));
      a2 = 32'h1000 + 32'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0:       ln = 2'd0;
        1:       ln = 2'd1;
        default: ln = 2'd3;
      endcase
      wd = $urandom;
      case (kind)
        0: void'(add_seg(1'b1, 1'b0, a, 2'd3, 0, -1, 1'b0, 0));
        1: void'(add_seg(1'b0, 1'b0, a, ln, 0, -1, 1'b0, 0));
        2: void'(add_seg(1'b0, 1'b1, a, ln, wd, -1, 1'b0, 0));
        3: begin
          void'(add_seg(1'b0, 1'($urandom_range(0, 1)), a, ln, wd, -1, 1'b1, a2));
          void'(add_seg(1'b1, 1'b0, a2, 2'd3, 0, -1, 1'b0, 0));
        end
        4: void'(add_seg(1'b1, 1'b0, a, 2'd3, 0, int'($urandom_range(1, 5)), 1'b0, 0));
        default: add_idle(int'($urandom_range(1, 3)));
      endcase
    end
    add_idle(2);
    play(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
